instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming ARM-subset instruction encoder and instruction-memory loader, the inverse of the control decoder. Each accepted field bundle (kind, cond, cmd, S/L, I, Rn, Rd, Rm, immediate) is checked against the subset the decoder supports and packed into a 32-bit word. The word is then emitted with an auto-incrementing byte address toward the instruction-memory write port. It sits between the bench or boot-loader front end and imem, so programs can be built from fields rather than hand-assembled hex.

## Interface
- DEPTH, 64: instruction-memory depth in words; must be a power of two.
- ADDR_W, 32: width of out_addr (byte address).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous restart: address to 0, pending word dropped, full cleared.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid & in_ready.
- in_kind  in  2  00 data-processing, 01 memory, 10 branch, 11 illegal.
- in_cond  in  4  condition field.
- in_i  in  1  immediate source2 (DP/MEM).
- in_cmd  in  4  DP opcode.
- in_s  in  1  DP S bit; for MEM this bit is L (1 = LDR).
- in_rn, in_rd, in_rm  in  4 each  register fields.
- in_imm  in  24  immediate (DP imm8, MEM imm12, branch imm24).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  sink accepts word.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  byte address of out_instr.
- err  out  1  one-cycle pulse: last accepted bundle illegal, dropped.
- full  out  1  DEPTH words emitted; no further acceptance until clr.
- err_count  out  8  saturating count of illegal bundles.

## Operation
- Packing (common): [31:28]=cond, [27:26]=kind.
- DP: [25]=I, [24:21]=cmd, [20]=S, [19:16]=Rn, [15:12]=Rd. [11:0] = {4'b0000, imm[7:0]} if I=1, else {8'b0, Rm}.
- MEM: [25]=~I, [24:21]=4'b1100 (P=1, U=1, B=0, W=0), [20]=L, Rn, Rd. [11:0] = imm[11:0] if I=1, else {8'b0, Rm}.
- Branch: [25:24]=2'b10, [23:0]=imm.
- Legal DP cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP.
- CMP with S=0 is legal only with I=1 (SLT form); CMP with S=0 and I=0 is illegal.
- Other illegal bundles: any other cmd; DP I=1 with imm[23:8]≠0; MEM I=1 with imm[23:12]≠0; kind 11.
- Illegal bundle: handshake completes, no out_valid, err pulses, err_count++ (saturates at 255), address unchanged.
- Address: starts at 0, +4 per out handshake. After the handshake at address 4*(DEPTH-1), full=1 and the address wraps to 0.
- in_ready = reset deasserted & !clr & !full & (!out_valid | out_ready). A single output register gives full throughput.
- FSM: EMPTY (out_valid=0), HOLD (out_valid=1).
  - EMPTY→HOLD on legal accept.
  - HOLD→EMPTY on out handshake with no new legal accept.
  - HOLD→HOLD on out handshake with a simultaneous legal accept.
- clr has priority over everything: state EMPTY, address 0, full 0. err_count is kept.

## Timing
- Reset values: out_valid 0, out_instr 0, out_addr 0, err 0, full 0, err_count 0, in_ready 0 during reset.
- Latency: bundle accepted at edge T appears on out_instr/out_valid after T; err for an illegal bundle is high for exactly the cycle after T.
- out_instr and out_addr are stable while out_valid & !out_ready.
- Reset mid-operation: the pending word is lost and all outputs return to reset values immediately, since reset is asynchronous.

## Structure
- Package arm_enc_pkg holds:
  - kind codes (KIND_DP, KIND_MEM, KIND_BR);
  - cmd constants (CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP);
  - COND_AL = 4'b1110;
  - FSM state enum.
- Sub-module instr_pack: purely combinational field→word packing plus a legal flag. The top holds the FSM, address counter, full flag and error counter.

## Test plan
- DP immediate: ADD AL, Rn=1, Rd=2, I=1, imm=0x05 → out_instr 0xE2812005 at out_addr 0; second word at 4.
- Branch: kind=10, cond=AL, imm=0xFFFFFE → 0xEAFFFFFE. LDR Rn=0, Rd=3, I=1, imm=8 → 0xE5903008.
- Illegal: cmd 1111, then DP I=1 imm=0x100 → no out_valid, two err pulses, err_count=2, next legal word still at address 0.
- Backpressure: out_ready low for 5 cycles with in_valid high → in_ready low and out_instr/out_addr frozen. Release → one word per cycle with contiguous addresses.
- DEPTH=4: emit 4 words → full=1 after the 4th, in_ready=0. clr → full=0, next word at address 0.
- Async reset asserted while in HOLD → out_valid 0 immediately; after release the first word is at address 0.

Source files
------------

// File: rtl/arm_enc_pkg.sv
// Shared codes for the ARM-subset instruction encoder: kinds, DP opcodes,
// condition codes and the output-stage FSM state.
package arm_enc_pkg;

    localparam logic [1:0] KIND_DP  = 2'b00;
    localparam logic [1:0] KIND_MEM = 2'b01;
    localparam logic [1:0] KIND_BR  = 2'b10;
    localparam logic [1:0] KIND_ILL = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_AL = 4'b1110;

    // Memory ops are always pre-indexed, add-offset, word, no write-back.
    localparam logic [3:0] MEM_PUBW = 4'b1100;
    localparam logic [1:0] BR_OP    = 2'b10;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } enc_state_e;

    function automatic logic dp_cmd_ok(input logic [3:0] cmd);
        logic ok;
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer; flags bundles outside the decoder's subset.
module instr_pack
    import arm_enc_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [3:0]  cond,
    input  logic        i,
    input  logic [3:0]  cmd,
    input  logic        s,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rm,
    input  logic [23:0] imm,
    output logic [31:0] instr,
    output logic        legal
);

    logic [11:0] dp_src2_s;
    logic [11:0] mem_src2_s;

    // Operand-2 fields for the register and immediate forms.
    always_comb begin
        dp_src2_s  = 12'h000;
        mem_src2_s = 12'h000;
        if (i) begin
            dp_src2_s  = {4'b0000, imm[7:0]};
            mem_src2_s = imm[11:0];
        end else begin
            dp_src2_s  = {8'h00, rm};
            mem_src2_s = {8'h00, rm};
        end
    end

    // Word packing and legality per instruction kind.
    always_comb begin
        instr = 32'h0000_0000;
        legal = 1'b0;
        case (kind)
            KIND_DP: begin
                instr = {cond, KIND_DP, i, cmd, s, rn, rd, dp_src2_s};
                if (!dp_cmd_ok(cmd)) begin
                    legal = 1'b0;
                end else if ((cmd == CMD_CMP) && !s && !i) begin
                    // CMP without S is only meaningful as the SLT immediate form.
                    legal = 1'b0;
                end else if (i && (imm[23:8] != 16'h0000)) begin
                    legal = 1'b0;
                end else begin
                    legal = 1'b1;
                end
            end
            KIND_MEM: begin
                // The decoder reads [25] as "register offset", hence the inversion.
                instr = {cond, KIND_MEM, ~i, MEM_PUBW, s, rn, rd, mem_src2_s};
                if (i && (imm[23:12] != 12'h000)) begin
                    legal = 1'b0;
                end else begin
                    legal = 1'b1;
                end
            end
            KIND_BR: begin
                instr = {cond, BR_OP, BR_OP, imm};
                legal = 1'b1;
            end
            default: begin
                instr = 32'h0000_0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder / imem loader: one-entry output register,
// auto-incrementing byte address, full flag and saturating illegal count.
module instr_encoder
    import arm_enc_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [3:0]        in_cond,
    input  logic              in_i,
    input  logic [3:0]        in_cmd,
    input  logic              in_s,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rm,
    input  logic [23:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic              full,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(4 * (DEPTH - 1));
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    enc_state_e        state_r;
    enc_state_e        state_nxt_s;
    logic [31:0]       instr_r;
    logic [ADDR_W-1:0] addr_r;
    logic              full_r;
    logic              err_r;
    logic [7:0]        err_count_r;

    logic [31:0]       packed_s;
    logic              legal_s;
    logic              accept_s;
    logic              load_s;
    logic              out_hs_s;

    instr_pack u_pack (
        .kind  (in_kind),
        .cond  (in_cond),
        .i     (in_i),
        .cmd   (in_cmd),
        .s     (in_s),
        .rn    (in_rn),
        .rd    (in_rd),
        .rm    (in_rm),
        .imm   (in_imm),
        .instr (packed_s),
        .legal (legal_s)
    );

    assign in_ready = reset & ~clr & ~full_r & (~out_valid | out_ready);
    assign accept_s = in_valid & in_ready;
    assign load_s   = accept_s & legal_s;
    assign out_hs_s = out_valid & out_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_EMPTY;
        end else if (clr) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (load_s) state_nxt_s = ST_HOLD;
                else        state_nxt_s = ST_EMPTY;
            end
            ST_HOLD: begin
                if (out_hs_s && !load_s) state_nxt_s = ST_EMPTY;
                else                     state_nxt_s = ST_HOLD;
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // FSM outputs.
    always_comb begin
        out_valid = 1'b0;
        case (state_r)
            ST_HOLD:  out_valid = 1'b1;
            ST_EMPTY: out_valid = 1'b0;
            default:  out_valid = 1'b0;
        endcase
    end

    // Output word register: only overwritten when a legal bundle is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_r <= 32'h0000_0000;
        end else if (clr) begin
            instr_r <= 32'h0000_0000;
        end else if (load_s) begin
            instr_r <= packed_s;
        end
    end

    // Byte address and full flag advance on every output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r <= '0;
            full_r <= 1'b0;
        end else if (clr) begin
            addr_r <= '0;
            full_r <= 1'b0;
        end else if (out_hs_s) begin
            if (addr_r == LAST_ADDR) begin
                addr_r <= '0;
                full_r <= 1'b1;
            end else begin
                addr_r <= addr_r + ADDR_STEP;
            end
        end
    end

    // Illegal-bundle pulse and saturating counter; the count survives clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r       <= 1'b0;
            err_count_r <= 8'h00;
        end else if (clr) begin
            err_r <= 1'b0;
        end else begin
            err_r <= accept_s & ~legal_s;
            if (accept_s && !legal_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    assign out_instr = instr_r;
    assign out_addr  = addr_r;
    assign full      = full_r;
    assign err       = err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4) with hand-computed expected words.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [3:0]  in_cond;
    logic        in_i;
    logic [3:0]  in_cmd;
    logic        in_s;
    logic [3:0]  in_rn;
    logic [3:0]  in_rd;
    logic [3:0]  in_rm;
    logic [23:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic        full;
    logic [7:0]  err_count;

    int checks = 0;
    int fails  = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_cond   (in_cond),
        .in_i      (in_i),
        .in_cmd    (in_cmd),
        .in_s      (in_s),
        .in_rn     (in_rn),
        .in_rd     (in_rd),
        .in_rm     (in_rm),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .full      (full),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [3:0] c, input logic ii,
                         input logic [3:0] cm, input logic ss, input logic [3:0] n,
                         input logic [3:0] d, input logic [3:0] m, input logic [23:0] im);
        in_valid = 1'b1;
        in_kind  = k;
        in_cond  = c;
        in_i     = ii;
        in_cmd   = cm;
        in_s     = ss;
        in_rn    = n;
        in_rd    = d;
        in_rm    = m;
        in_imm   = im;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_kind = 2'b00; in_cond = 4'h0; in_i = 1'b0; in_cmd = 4'h0;
        in_s = 1'b0; in_rn = 4'h0; in_rd = 4'h0; in_rm = 4'h0; in_imm = 24'h0;
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // DP immediate ADD, then a register-form SUB streamed back to back.
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000005);
        step();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_instr", out_instr, 32'hE2812005);
        chk("add_addr", out_addr, 32'd0);
        drive(2'b00, 4'hE, 1'b0, 4'b0010, 1'b1, 4'd3, 4'd4, 4'd5, 24'h000000);
        step();
        chk("sub_instr", out_instr, 32'hE0534005);
        chk("sub_addr", out_addr, 32'd4);
        in_valid = 1'b0;
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_addr", out_addr, 32'd8);
        pulse_clr();
        chk("clr_addr", out_addr, 32'd0);

        // Branch and LDR.
        drive(2'b10, 4'hE, 1'b0, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE);
        step();
        chk("br_instr", out_instr, 32'hEAFFFFFE);
        chk("br_addr", out_addr, 32'd0);
        drive(2'b01, 4'hE, 1'b1, 4'h0, 1'b1, 4'd0, 4'd3, 4'd0, 24'h000008);
        step();
        chk("ldr_instr", out_instr, 32'hE5903008);
        chk("ldr_addr", out_addr, 32'd4);
        in_valid = 1'b0;
        step();
        pulse_clr();

        // Illegal bundles: bad cmd, oversized imm, kind 11, CMP register form without S.
        drive(2'b00, 4'hE, 1'b0, 4'b1111, 1'b0, 4'd1, 4'd2, 4'd3, 24'h000000);
        step();
        chk("ill_cmd_err", {31'd0, err}, 32'd1);
        chk("ill_cmd_valid", {31'd0, out_valid}, 32'd0);
        chk("ill_cmd_cnt", {24'd0, err_count}, 32'd1);
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000100);
        step();
        chk("ill_imm_err", {31'd0, err}, 32'd1);
        chk("ill_imm_cnt", {24'd0, err_count}, 32'd2);
        drive(2'b11, 4'hE, 1'b0, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd3, 24'h000000);
        step();
        drive(2'b00, 4'hE, 1'b0, 4'b1010, 1'b0, 4'd1, 4'd2, 4'd3, 24'h000000);
        step();
        chk("ill_cmp_cnt", {24'd0, err_count}, 32'd4);
        in_valid = 1'b0;
        step();
        chk("ill_err_low", {31'd0, err}, 32'd0);
        chk("ill_no_valid", {31'd0, out_valid}, 32'd0);
        chk("ill_addr_kept", out_addr, 32'd0);
        drive(2'b00, 4'hE, 1'b1, 4'b1010, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000007);
        step();
        chk("slt_instr", out_instr, 32'hE3412007);
        chk("slt_addr", out_addr, 32'd0);
        chk("slt_err", {31'd0, err}, 32'd0);
        in_valid = 1'b0;
        step();
        pulse_clr();
        chk("clr_keeps_cnt", {24'd0, err_count}, 32'd4);

        // Backpressure, streaming release, then fill to DEPTH.
        out_ready = 1'b0;
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000001);
        step();
        chk("bp_first", out_instr, 32'hE2812001);
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000002);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_instr", out_instr, 32'hE2812001);
            chk("bp_addr", out_addr, 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("rel1_instr", out_instr, 32'hE2812002);
        chk("rel1_addr", out_addr, 32'd4);
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000003);
        step();
        chk("rel2_instr", out_instr, 32'hE2812003);
        chk("rel2_addr", out_addr, 32'd8);
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000004);
        step();
        chk("rel3_instr", out_instr, 32'hE2812004);
        chk("rel3_addr", out_addr, 32'd12);
        chk("rel3_not_full", {31'd0, full}, 32'd0);
        in_valid = 1'b0;
        step();
        chk("full_set", {31'd0, full}, 32'd1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_addr_wrap", out_addr, 32'd0);
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000005);
        step();
        chk("full_no_accept", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        pulse_clr();
        chk("clr_full", {31'd0, full}, 32'd0);
        out_ready = 1'b0;
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000005);
        step();
        in_valid = 1'b0;
        chk("after_clr_addr", out_addr, 32'd0);
        chk("after_clr_instr", out_instr, 32'hE2812005);

        // Async reset while holding a word.
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_instr", out_instr, 32'h0);
        chk("async_cnt", {24'd0, err_count}, 32'd0);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        drive(2'b00, 4'hE, 1'b0, 4'b1100, 1'b0, 4'd1, 4'd2, 4'd3, 24'h000000);
        step();
        chk("post_async_instr", out_instr, 32'hE1812003);
        chk("post_async_addr", out_addr, 32'd0);
        in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
